// File: rtl/qc_inst_pkg.sv
// Shared types for the QC instruction dispatcher: instruction field layout,
// opcode values and dispatcher FSM states.
package qc_inst_pkg;

  localparam int OPC_W     = 4;
  localparam int DELAY_W   = 18;
  localparam int PAYLOAD_W = 16;
  localparam int DATA_W    = OPC_W + DELAY_W + PAYLOAD_W;
  localparam int TIME_W    = 32;

  localparam int OPC_MSB = DATA_W - 1;
  localparam int OPC_LSB = DELAY_W + PAYLOAD_W;
  localparam int DLY_MSB = DELAY_W + PAYLOAD_W - 1;
  localparam int DLY_LSB = PAYLOAD_W;
  localparam int PL_MSB  = PAYLOAD_W - 1;
  localparam int PL_LSB  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'd0,
    OP_PULSE = 4'd1,
    OP_SYNC  = 4'd2,
    OP_HALT  = 4'd3
  } opcode_e;

  typedef struct packed {
    logic [OPC_W-1:0]     opc;
    logic [DELAY_W-1:0]   delay;
    logic [PAYLOAD_W-1:0] payload;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_ISSUE,
    S_SYNC
  } disp_state_e;

  // HALT and illegal opcodes execute from WAIT with the counter at zero,
  // so they get a visible action cycle just like ISSUE/SYNC do.
  function automatic disp_state_e action_state(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_NOP:   action_state = S_FETCH;
      OP_PULSE: action_state = S_ISSUE;
      OP_SYNC:  action_state = S_SYNC;
      default:  action_state = S_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/inst_dispatcher.sv
// Instruction FIFO consumer: pops timed instructions, waits their delay,
// then issues a payload, waits for sync, idles, or halts.
module inst_dispatcher
  import qc_inst_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int OPC_WIDTH     = OPC_W,
  parameter int DELAY_WIDTH   = DELAY_W,
  parameter int PAYLOAD_WIDTH = PAYLOAD_W,
  parameter int TIME_WIDTH    = TIME_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]    fifo_data,
  input  logic                     sync_trig,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     busy,
  output logic                     done,
  output logic                     err_illegal,
  output logic                     underrun,
  output logic [TIME_WIDTH-1:0]    prog_time
);

  disp_state_e              state_q, state_d;
  logic [OPC_WIDTH-1:0]     opc_q;
  logic [DELAY_WIDTH-1:0]   cnt_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  logic                     first_done_q;

  logic [OPC_WIDTH-1:0]     opc_in;
  logic [DELAY_WIDTH-1:0]   dly_in;
  logic [PAYLOAD_WIDTH-1:0] pl_in;
  logic                     exec_now;
  logic                     legal_op;

  assign opc_in   = fifo_data[OPC_MSB:OPC_LSB];
  assign dly_in   = fifo_data[DLY_MSB:DLY_LSB];
  assign pl_in    = fifo_data[PL_MSB:PL_LSB];
  assign exec_now = (state_q == S_WAIT) && (cnt_q == '0) && !abort;
  assign legal_op = (opc_q == OP_NOP) || (opc_q == OP_PULSE) ||
                    (opc_q == OP_SYNC) || (opc_q == OP_HALT);

  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_ISSUE);
  assign out_payload = payload_q;

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: state_d = (dly_in == '0) ? action_state(opc_in) : S_WAIT;
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done    = (opc_q == OP_HALT);
        end else if (cnt_q == DELAY_WIDTH'(1)) begin
          state_d = action_state(opc_q);
        end
      end
      S_ISSUE:  if (out_ready) state_d = S_FETCH;
      S_SYNC:   if (sync_trig) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      fifo_rd_en = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      opc_q        <= '0;
      cnt_q        <= '0;
      payload_q    <= '0;
      first_done_q <= 1'b0;
      err_illegal  <= 1'b0;
      underrun     <= 1'b0;
      prog_time    <= '0;
    end else begin
      state_q <= state_d;
      if (busy) prog_time <= prog_time + TIME_WIDTH'(1);
      if (abort) begin
        cnt_q     <= '0;
        payload_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              err_illegal  <= 1'b0;
              underrun     <= 1'b0;
              prog_time    <= '0;
              first_done_q <= 1'b0;
            end
          end
          S_FETCH:  if (fifo_empty && first_done_q) underrun <= 1'b1;
          S_DECODE: begin
            opc_q        <= opc_in;
            cnt_q        <= dly_in;
            payload_q    <= pl_in;
            first_done_q <= 1'b1;
          end
          S_WAIT: begin
            if (cnt_q != '0) cnt_q <= cnt_q - DELAY_WIDTH'(1);
            if (exec_now && !legal_op) err_illegal <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
